// File: rtl/div_initiator_pkg.sv
// Shared definitions for the divider initiator: default width, error
// encodings, FSM state type and a helper for counter sizing.
package div_initiator_pkg;

  localparam int WIDTH_DEF = 64;

  // Error flags returned with every response; zero means a good result.
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_DIVZERO = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bits needed for a counter that must be able to hold the value 'term'.
  function automatic int timer_width(input int term);
    return $clog2(term + 1);
  endfunction

endpackage

// File: rtl/div_initiator_cycle_timer.sv
// Saturating cycle counter with synchronous clear. Counts enabled cycles
// from zero and stops at TERMINAL. o_reach flags the enabled cycle whose
// increment lands exactly on TERMINAL, i.e. the TERMINAL-th counted cycle.
module div_initiator_cycle_timer #(
  parameter int TERMINAL = 256,
  parameter int CW       = $clog2(TERMINAL + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_enable,
  output logic [CW-1:0] o_count,
  output logic          o_reach
);

  logic [CW-1:0] r_count;
  logic          w_at_term;

  assign w_at_term = (r_count == CW'(TERMINAL));
  assign o_reach   = i_enable && (r_count == CW'(TERMINAL - 1));
  assign o_count   = r_count;

  // Clear wins over counting; the count holds once it hits TERMINAL.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable && !w_at_term) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/div_initiator.sv
// Command-side initiator for the multi-cycle binary divider. Takes (a,b)
// on a valid/ready request port, holds the divider in reset for SETUP_CYC
// cycles with stable operands, releases it, waits for div_ready_n to fall
// (ignoring it in the first run cycle, where it may be stale), then returns
// q/r with error flags on a valid/ready response port. Divide-by-zero is
// answered locally without starting the divider; a hung divider is aborted
// after TIMEOUT run cycles.
module div_initiator
  import div_initiator_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int SETUP_CYC = 2,
  parameter int TIMEOUT   = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [WIDTH-1:0] i_req_a,
  input  logic [WIDTH-1:0] i_req_b,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp_q,
  output logic [WIDTH-1:0] o_rsp_r,
  output logic [1:0]       o_rsp_err,
  output logic [WIDTH-1:0] o_div_a,
  output logic [WIDTH-1:0] o_div_b,
  output logic             o_div_rst_n,
  input  logic [WIDTH-1:0] i_div_q,
  input  logic [WIDTH-1:0] i_div_r,
  input  logic             i_div_ready_n
);

  localparam int CW = timer_width(TIMEOUT);

  state_t           r_state;
  logic             r_req_ready;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_q;
  logic [WIDTH-1:0] r_rsp_r;
  logic [1:0]       r_rsp_err;
  logic [WIDTH-1:0] r_div_a;
  logic [WIDTH-1:0] r_div_b;
  logic             r_div_rst_n;

  logic [CW-1:0]    w_count;
  logic             w_reach;
  logic             w_timer_clear;
  logic             w_timer_en;
  logic             w_divzero;
  logic             w_setup_last;
  logic             w_run_done;
  logic             w_timeout;

  // One timer serves both phases: it is zeroed on entry to SETUP and again
  // on entry to RUN, so in RUN the count equals run cycles already elapsed.
  assign w_timer_clear = (r_state == IDLE) || (r_state == DONE) ||
                         ((r_state == SETUP) && w_setup_last);
  assign w_timer_en    = (r_state == SETUP) || (r_state == RUN);

  div_initiator_cycle_timer #(
    .TERMINAL (TIMEOUT),
    .CW       (CW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_timer_clear),
    .i_enable (w_timer_en),
    .o_count  (w_count),
    .o_reach  (w_reach)
  );

  assign w_divzero    = (i_req_b == '0);
  assign w_setup_last = (w_count == CW'(SETUP_CYC - 1));
  // Count zero is the first run cycle: a low div_ready_n there may be left
  // over from the previous operation, so it is not trusted.
  assign w_run_done   = (w_count != '0) && !i_div_ready_n;
  assign w_timeout    = (r_state == RUN) && w_reach;

  // Control FSM and all registered datapath/handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_q     <= '0;
      r_rsp_r     <= '0;
      r_rsp_err   <= ERR_NONE;
      r_div_a     <= '0;
      r_div_b     <= '0;
      r_div_rst_n <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_req_valid) begin
            r_req_ready <= 1'b0;
            r_div_a     <= i_req_a;
            r_div_b     <= i_req_b;
            if (w_divzero) begin
              r_rsp_q     <= '1;
              r_rsp_r     <= i_req_a;
              r_rsp_err   <= ERR_DIVZERO;
              r_rsp_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_state <= SETUP;
            end
          end
        end
        SETUP: begin
          if (w_setup_last) begin
            r_div_rst_n <= 1'b1;
            r_state     <= RUN;
          end
        end
        RUN: begin
          // A genuine completion on the final allowed cycle still counts.
          if (w_run_done) begin
            r_rsp_q     <= i_div_q;
            r_rsp_r     <= i_div_r;
            r_rsp_err   <= ERR_NONE;
            r_rsp_valid <= 1'b1;
            r_div_rst_n <= 1'b0;
            r_state     <= DONE;
          end else if (w_timeout) begin
            r_rsp_q     <= '0;
            r_rsp_r     <= '0;
            r_rsp_err   <= ERR_TIMEOUT;
            r_rsp_valid <= 1'b1;
            r_div_rst_n <= 1'b0;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_q     = r_rsp_q;
  assign o_rsp_r     = r_rsp_r;
  assign o_rsp_err   = r_rsp_err;
  assign o_div_a     = r_div_a;
  assign o_div_b     = r_div_b;
  assign o_div_rst_n = r_div_rst_n;

endmodule
